ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch stage of the 5-stage MIPS CPU. It sits directly downstream of the program counter: it takes the current `pc`, issues a request to instruction memory over a req/ack handshake, and buffers returned instructions with their addresses in a small skid FIFO feeding decode. It tells the PC stage when to advance (`pc_hold`) and discards wrong-path instructions on a branch redirect (`flush`).

## Interface
- `AW`, 32, address width
- `DW`, 32, instruction width
- `DEPTH`, 2, skid FIFO entries (power of two, ≥2)

- `clk`  in  1  clock; all state updates on posedge
- `reset`  in  1  asynchronous, active-high
- `pc`  in  AW  fetch address from PC stage
- `pc_hold`  out  1  high = PC stage must not advance; redirect loads take priority over hold
- `flush`  in  1  branch redirect; high for one cycle
- `imem_req`  out  1  fetch request
- `imem_addr`  out  AW  fetch address; stable while `imem_req` high
- `imem_ack`  in  1  `imem_rdata` valid this cycle
- `imem_rdata`  in  DW  fetched instruction
- `stall`  in  1  decode cannot accept this cycle
- `id_valid`  out  1  FIFO head valid
- `id_inst`  out  DW  head instruction
- `id_pc`  out  AW  head instruction address
- `id_pc4`  out  AW  `id_pc + 4`, modulo 2^AW; branch base for stage 3

## Operation
- FSM states: IDLE, FETCH, DRAIN.
- **IDLE**
  - Entered on reset.
  - `imem_req=0`, `pc_hold=1`.
  - Moves to FETCH after one cycle.
- **FETCH**
  - Issue rule: a request is issued when no request is outstanding and `count < DEPTH`. `count` is the occupancy after the current cycle's push/pop.
  - On issue: `imem_addr` is latched from `pc`, and `imem_req` is held high until `imem_ack` is sampled.
  - At most one request is outstanding, so the FIFO never overflows.
  - Accept: a cycle with `imem_req && imem_ack && !flush` pushes {`imem_addr`, `imem_rdata`}.
  - `pc_hold` is low only in an accept cycle, so the PC advances exactly once per accepted fetch.
- **Pop**: a cycle with `id_valid && !stall` pops the head. Push and pop may occur in the same cycle, and `count` is then unchanged.
- **Flush**
  - Next edge: FIFO cleared and `id_valid=0`.
  - If a request was outstanding and `imem_ack` was low in the flush cycle, the state moves to DRAIN.
  - If ack arrived in the flush cycle, its data is dropped and the state stays in FETCH.
- **DRAIN**
  - `imem_req` stays high (handshake not abandoned) and `pc_hold=1`.
  - The data returned on ack is discarded; the state then moves to FETCH.
- **Priorities**: `flush` overrides push, pop and `stall` in the same cycle.
- **Wrap**: `pc + 4` wraps at 2^AW with no flag.

## Timing
- **Reset values**: `imem_req=0`, `imem_addr=0`, `pc_hold=1`, `id_valid=0`, `id_inst=32'h00000000` (NOP), `id_pc=0`, `id_pc4=4`.
- **Latency**
  - `imem_ack` may arrive as early as the first cycle `imem_req` is high (zero wait states).
  - With a zero-wait memory and no stall, the first request is issued in the cycle after IDLE.
  - Data is visible at `id_*` one cycle after ack, and sustained throughput is 1 instruction per 2 cycles (issue/ack, then re-issue).
- **Flush timing**: the PC stage presents the redirect target by the cycle after `flush`. Fetch resumes from that `pc` in that cycle if nothing is outstanding; otherwise it resumes the cycle after the DRAIN ack.
- **Reset mid-request**: all state clears immediately and `imem_req` drops asynchronously. Instruction memory must tolerate an abandoned request on reset.
- `id_*` are registered FIFO head outputs; no combinational path from `imem_rdata` to `id_inst`.

## Structure
- **Shared package `mips_pkg`**:
  - `INST_NOP = 32'h00000000`
  - `PC_RESET = 32'h00000000`
  - address/instruction width constants
  - FIFO entry struct {addr, inst}
- **Sub-module `ifetch_buf`**: a parameterised DEPTH-entry synchronous FIFO with asynchronous active-high reset. It provides push/pop/clear, `count`, and head outputs; the FSM and handshake live in `ifetch`.

## Test plan
- Reset, zero-wait memory returning `addr ^ 32'hFFFF0000`, `stall=0`:
  - First request has `imem_addr=0`.
  - `id_pc` sequence is 0, 4, 8, 12.
  - `id_inst` matches, and `id_pc4 = id_pc + 4`.
- Hold `stall=1` for 10 cycles:
  - FIFO fills to 2, `imem_req` stays low, `pc_hold=1`.
  - On release, entries 0 and 4 pop in order with no loss or duplication.
- 3-wait-state memory, `flush` asserted while the request for 0x10 is outstanding:
  - Data for 0x10 is discarded, and `id_valid=0` the cycle after flush.
  - After DRAIN, next fetch is the target 0x40.
- Flush in the same cycle as ack and a pop: nothing pushed, FIFO empty next cycle, and fetch resumes from the new `pc`.
- Assert `reset` mid-request:
  - All outputs return to their reset values asynchronously.
  - After release, fetch restarts at 0 via IDLE.
- `pc = 32'hFFFFFFFC`: `id_pc4 = 0`, and the next fetch is 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS pipeline front end.
//   ADDR_W / INST_W : address and instruction widths
//   INST_NOP        : all-zero instruction (sll $0,$0,0)
//   PC_RESET        : fetch address after reset
//   fetch_entry_t   : one fetched instruction with its address
//   ifetch_state_t  : fetch FSM states
package mips_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;

  localparam logic [INST_W-1:0] INST_NOP = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] PC_RESET = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  localparam fetch_entry_t FETCH_ENTRY_RESET = '{addr: PC_RESET, inst: INST_NOP};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } ifetch_state_t;

endpackage

// File: rtl/ifetch_buf.sv
// Skid FIFO between instruction fetch and decode.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : drop all entries at the next edge (wins over push/pop)
//   push/wdata : write one entry at the tail
//   pop        : retire the head entry
//   head       : current head entry (registered storage, no bypass)
//   count      : number of valid entries
module ifetch_buf
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear,
  input  logic                           push,
  input  logic                           pop,
  input  fetch_entry_t                   wdata,
  output fetch_entry_t                   head,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_entry_t [DEPTH-1:0] mem;
  logic [PW-1:0]            rd_ptr;
  logic [PW-1:0]            wr_ptr;
  logic                     do_push;
  logic                     do_pop;

  assign do_push = push && !clear;
  assign do_pop  = pop && !clear && (count != '0);

  // Storage resets to NOP entries so the head reads {PC_RESET, INST_NOP} out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem    <= {DEPTH{FETCH_ENTRY_RESET}};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: issues one imem request at a time from pc,
// buffers returned instructions in a skid FIFO for decode, and handles
// branch redirects (flush), including draining an abandoned-in-flight fetch.
//   clk, reset          : clock, asynchronous active-high reset
//   pc / pc_hold        : fetch address in; hold request to the PC stage out
//   flush               : one-cycle branch redirect
//   imem_req/addr/ack/rdata : instruction memory handshake
//   stall               : decode cannot accept this cycle
//   id_valid/inst/pc/pc4: FIFO head presented to decode
module ifetch
  import mips_pkg::*;
#(
  parameter int unsigned AW    = ADDR_W,
  parameter int unsigned DW    = INST_W,
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc,
  output logic          pc_hold,
  input  logic          flush,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [DW-1:0] imem_rdata,
  input  logic          stall,
  output logic          id_valid,
  output logic [DW-1:0] id_inst,
  output logic [AW-1:0] id_pc,
  output logic [AW-1:0] id_pc4
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  ifetch_state_t state;
  ifetch_state_t state_next;
  logic          req_next;
  logic [AW-1:0] addr_next;
  logic          accept;
  logic          pop;
  logic          issue;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, accept/pop/issue decisions and PC hold.
  always_comb begin
    state_next = state;
    pc_hold    = 1'b1;
    accept     = 1'b0;
    pop        = id_valid && !stall && !flush;
    issue      = 1'b0;
    req_next   = imem_req;
    addr_next  = imem_addr;

    case (state)
      IDLE: begin
        state_next = FETCH;
      end
      FETCH: begin
        accept  = imem_req && imem_ack && !flush;
        pc_hold = !accept;
        // A redirect with the fetch still in flight must wait out its ack.
        if (flush && imem_req && !imem_ack) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (imem_ack) begin
          state_next = FETCH;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    count_next = flush ? '0 : (count + CW'(accept) - CW'(pop));

    // A request is never issued in the cycle its predecessor completes, so pc
    // has already advanced past the accepted address when it is latched. No
    // issue during flush either: the redirect target arrives next cycle.
    issue = (state != DRAIN) && !imem_req && !flush && (count_next < CW'(DEPTH));

    if (issue) begin
      req_next  = 1'b1;
      addr_next = pc;
    end else if (imem_req && imem_ack) begin
      req_next  = 1'b0;
    end
  end

  // Memory request registers; address is held for the whole handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imem_req  <= 1'b0;
      imem_addr <= AW'(PC_RESET);
    end else begin
      imem_req  <= req_next;
      imem_addr <= addr_next;
    end
  end

  assign push_entry = '{addr: ADDR_W'(imem_addr), inst: INST_W'(imem_rdata)};

  ifetch_buf #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .push  (accept),
    .pop   (pop),
    .wdata (push_entry),
    .head  (head),
    .count (count)
  );

  assign id_valid = (count != '0);
  assign id_inst  = DW'(head.inst);
  assign id_pc    = AW'(head.addr);
  assign id_pc4   = id_pc + AW'(4);

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch. A reference model tracks, at the level of
// program order, which instruction decode must see next, how many entries the
// buffer holds, and whether an in-flight fetch is being drained after a redirect.
module tb_ifetch;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] MASK  = 32'hFFFF0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        pc_hold;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;

  int checks   = 0;
  int failures = 0;

  int unsigned occ;
  int unsigned waits;
  int unsigned wcnt;
  int unsigned npops;
  bit          drain_pend;
  bit          prev_req;
  bit          prev_ack;
  logic [31:0] prev_addr;
  logic [31:0] exp_pc;
  logic [31:0] tgt;

  ifetch #(.AW(32), .DW(32), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .pc_hold    (pc_hold),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .id_valid   (id_valid),
    .id_inst    (id_inst),
    .id_pc      (id_pc),
    .id_pc4     (id_pc4)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    occ        = 0;
    wcnt       = 0;
    npops      = 0;
    drain_pend = 1'b0;
    prev_req   = 1'b0;
    prev_ack   = 1'b0;
    prev_addr  = 32'h0;
    exp_pc     = 32'h0;
    pc         = 32'h0;
    flush      = 1'b0;
    imem_ack   = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_imem_req"},  32'(imem_req), 32'd0);
    chk({tag, "_imem_addr"}, imem_addr,     32'h0);
    chk({tag, "_pc_hold"},   32'(pc_hold),  32'd1);
    chk({tag, "_id_valid"},  32'(id_valid), 32'd0);
    chk({tag, "_id_inst"},   id_inst,       32'h0);
    chk({tag, "_id_pc"},     id_pc,         32'h0);
    chk({tag, "_id_pc4"},    id_pc4,        32'h4);
  endtask

  // One clock cycle: memory and PC stage respond, model checks, edge, model update.
  // Entered and left at posedge+1.
  task automatic step();
    bit acc;
    bit pop;
    bit hold;
    bit fl;
    fl         = flush;
    imem_ack   = imem_req && (wcnt >= waits);
    imem_rdata = imem_addr ^ MASK;
    #1;
    acc = imem_req && imem_ack && !fl && !drain_pend;
    pop = (occ != 0) && !stall && !fl;
    chk("pc_hold", 32'(pc_hold), 32'(!acc));
    chk("id_valid", 32'(id_valid), 32'(occ != 0));
    if (occ >= DEPTH) chk("req_when_full", 32'(imem_req), 32'd0);
    if (prev_req && !prev_ack && imem_req) chk("addr_stable", imem_addr, prev_addr);
    if (pop) begin
      chk("id_pc", id_pc, exp_pc);
      chk("id_inst", id_inst, exp_pc ^ MASK);
      chk("id_pc4", id_pc4, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
      npops++;
    end
    if (fl) begin
      occ    = 0;
      exp_pc = tgt;
    end else begin
      occ = occ + 32'(acc) - 32'(pop);
    end
    if (fl && imem_req && !imem_ack) drain_pend = 1'b1;
    else if (imem_req && imem_ack)   drain_pend = 1'b0;
    hold      = pc_hold;
    prev_req  = imem_req;
    prev_ack  = imem_ack;
    prev_addr = imem_addr;
    @(posedge clk);
    #1;
    if (prev_req && prev_ack) wcnt = 0;
    else if (prev_req)        wcnt++;
    if (fl)         pc = tgt;
    else if (!hold) pc = pc + 32'd4;
    flush = 1'b0;
  endtask

  // Asynchronous reset assertion mid-cycle, checked before the next edge.
  task automatic do_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values(tag);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Runs until a fresh request appears, then checks its address.
  task automatic expect_next_req(input string tag, input logic [31:0] addr, input int max);
    bit found;
    found = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (imem_req && (!prev_req || prev_ack)) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk({tag, "_seen"}, 32'(found), 32'd1);
    if (found) chk({tag, "_addr"}, imem_addr, addr);
  endtask

  initial begin
    bit          found;
    int unsigned pops0;

    reset = 1'b1;
    stall = 1'b0;
    tgt   = 32'h0;
    imem_rdata = 32'h0;
    waits = 0;
    model_reset();
    #1;
    check_reset_values("init");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Zero-wait memory, no stall: in-order stream from 0 at 1 per 2 cycles.
    expect_next_req("first_req", 32'h0, 5);
    for (int i = 0; i < 11; i++) step();
    chk("throughput", 32'(npops >= 4 && npops <= 6), 32'd1);

    // Decode stalled: buffer fills and fetch stops.
    stall = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("fill_valid", 32'(id_valid), 32'd1);
    chk("fill_req", 32'(imem_req), 32'd0);
    chk("fill_hold", 32'(pc_hold), 32'd1);
    stall = 1'b0;
    for (int i = 0; i < 6; i++) step();

    // Three wait states, redirect to 0x40 while 0x10 is in flight.
    do_reset("rst3");
    waits = 3;
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (imem_req && imem_addr == 32'h10) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("req10_seen", 32'(found), 32'd1);
    flush = 1'b1;
    tgt   = 32'h40;
    step();
    chk("flush_valid", 32'(id_valid), 32'd0);
    expect_next_req("after_drain", 32'h40, 20);

    // Redirect in the same cycle as an ack and a would-be pop.
    waits = 0;
    stall = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (occ >= 1 && imem_req) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("ack_pop_setup", 32'(found), 32'd1);
    stall = 1'b0;
    flush = 1'b1;
    tgt   = 32'h100;
    step();
    chk("flush_ack_valid", 32'(id_valid), 32'd0);
    expect_next_req("after_ack_flush", 32'h100, 10);

    // Address wrap at the top of memory.
    flush = 1'b1;
    tgt   = 32'hFFFFFFFC;
    step();
    for (int i = 0; i < 40; i++) begin
      if (exp_pc == 32'h4) break;
      step();
    end
    chk("wrap_done", exp_pc, 32'h4);

    // Reset while a slow request is outstanding, then restart from 0.
    waits = 3;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("midreq_seen", 32'(found), 32'd1);
    do_reset("mid_req");
    waits = 0;
    expect_next_req("restart", 32'h0, 5);
    for (int i = 0; i < 8; i++) step();

    // Randomised traffic: stalls, variable wait states, redirects.
    pops0 = npops;
    for (int i = 0; i < 800; i++) begin
      if (i % 40 == 0) waits = $urandom_range(0, 3);
      stall = ($urandom_range(0, 99) < 30);
      if ($urandom_range(0, 99) < 4) begin
        flush = 1'b1;
        tgt   = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 : ($urandom & 32'hFFFFFFFC);
      end
      step();
    end
    chk("random_progress", 32'(npops - pops0 >= 20), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
